// File: rtl/mms_stream_loader_pkg.sv
// Shared types and constants for the stream-fed 4-number max/min loader.
package mms_stream_loader_pkg;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_CALC = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam logic SEL_MAX = 1'b0;
    localparam logic SEL_MIN = 1'b1;

    // Padding is a fill bit replicated to DATA_W: 0 for max, all-ones for min.
    localparam logic PAD_MAX = 1'b0;
    localparam logic PAD_MIN = 1'b1;

    function automatic logic pad_bit(input logic sel);
        return (sel == SEL_MIN) ? PAD_MIN : PAD_MAX;
    endfunction

endpackage

// File: rtl/mms_stream_loader_if.sv
// Input and output valid/ready handshakes of the max/min stream loader.
interface mms_stream_loader_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              in_select;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_result;
    logic              out_select;
    logic [2:0]        out_count;

    modport master (
        output in_valid, in_data, in_select, in_last, out_ready,
        input  in_ready, out_valid, out_result, out_select, out_count
    );

    modport slave (
        input  in_valid, in_data, in_select, in_last, out_ready,
        output in_ready, out_valid, out_result, out_select, out_count
    );
endinterface

// File: rtl/mms_cmp2.sv
// Two-input unsigned compare-select; a tie keeps the lower-index operand a.
module mms_cmp2
    import mms_stream_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              sel,
    output logic [DATA_W-1:0] win
);
    always_comb begin
        win = a;
        if (sel == SEL_MIN) begin
            if (b < a) win = b;
        end else begin
            if (a < b) win = b;
        end
    end
endmodule

// File: rtl/mms_stream_loader.sv
// Collects up to four numbers from a stream and returns their max or min.
module mms_stream_loader
    import mms_stream_loader_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                clk,
    input  logic                reset,
    mms_stream_loader_if.slave  bus
);
    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] slot_q [4];
    logic [DATA_W-1:0] slot_d [4];
    logic              sel_q, sel_d;
    logic              rdy_q, rdy_d;
    logic              out_valid_q, out_valid_d;
    logic [DATA_W-1:0] out_result_q, out_result_d;
    logic              out_select_q, out_select_d;
    logic [2:0]        out_count_q, out_count_d;

    logic [DATA_W-1:0] padded [4];
    logic [DATA_W-1:0] win_lo, win_hi, win;
    logic              in_ready;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            padded[i] = (3'(i) < cnt_q) ? slot_q[i]
                                        : {DATA_W{pad_bit(sel_q)}};
        end
    end

    mms_cmp2 #(.DATA_W(DATA_W)) u_cmp_lo (
        .a(padded[0]), .b(padded[1]), .sel(sel_q), .win(win_lo)
    );
    mms_cmp2 #(.DATA_W(DATA_W)) u_cmp_hi (
        .a(padded[2]), .b(padded[3]), .sel(sel_q), .win(win_hi)
    );
    mms_cmp2 #(.DATA_W(DATA_W)) u_cmp_top (
        .a(win_lo), .b(win_hi), .sel(sel_q), .win(win)
    );

    // rdy_q keeps in_ready low until the first clock after reset release.
    assign rdy_d = 1'b1;

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        slot_d       = slot_q;
        sel_d        = sel_q;
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_select_d = out_select_q;
        out_count_d  = out_count_q;
        in_ready     = 1'b0;
        unique case (state_q)
            ST_FILL: begin
                in_ready = rdy_q;
                if (bus.in_valid && rdy_q) begin
                    slot_d[cnt_q[1:0]] = bus.in_data;
                    if (cnt_q == 3'd0) sel_d = bus.in_select;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd3 || bus.in_last) state_d = ST_CALC;
                end
            end
            ST_CALC: begin
                out_valid_d  = 1'b1;
                out_result_d = win;
                out_select_d = sel_q;
                out_count_d  = cnt_q;
                state_d      = ST_OUT;
            end
            ST_OUT: begin
                if (bus.out_ready) begin
                    out_valid_d = 1'b0;
                    cnt_d       = 3'd0;
                    state_d     = ST_FILL;
                end
            end
            default: state_d = ST_FILL;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_FILL;
            cnt_q        <= 3'd0;
            slot_q       <= '{default: '0};
            sel_q        <= 1'b0;
            rdy_q        <= 1'b0;
            out_valid_q  <= 1'b0;
            out_result_q <= '0;
            out_select_q <= 1'b0;
            out_count_q  <= 3'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            slot_q       <= slot_d;
            sel_q        <= sel_d;
            rdy_q        <= rdy_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_select_q <= out_select_d;
            out_count_q  <= out_count_d;
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_select = out_select_q;
    assign bus.out_count  = out_count_q;
endmodule
